pc_ctrl_axil_bridge: RTL

//  AXI4-Lite slave to reg-bank initiator bridge. Drives the reg_bank_{rd,wr}_* strobe/addr/data bus

---
 rtl/pc_ctrl_pkg.sv | 15 +
 rtl/pc_ctrl_bridge_timeout.sv | 32 +++
 rtl/pc_ctrl_axil_bridge.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared constants and FSM encoding for the pc_ctrl AXI4-Lite to reg-bank bridge.
package pc_ctrl_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/pc_ctrl_bridge_timeout.sv
// Done-wait watchdog for the bridge: cleared on each grant, counts while waiting, flags expiry.
// Only instantiated when PC_CTRL_BRIDGE_TIMEOUT_EN is defined.
module pc_ctrl_bridge_timeout
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && (r_cnt != CW'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The wait phase lasts exactly TIMEOUT_CYCLES cycles when no done arrives.
  assign o_expired = i_count_en && (r_cnt >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pc_ctrl_axil_bridge.sv
// AXI4-Lite slave that serialises host accesses onto the pc_ctrl reg-bank strobe bus.
// Optional done-wait timeout enabled by defining PC_CTRL_BRIDGE_TIMEOUT_EN.
module pc_ctrl_axil_bridge
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W_IN_BYTES  = 4,
  parameter int unsigned ADDR_W_IN_BITS   = 32,
  parameter int unsigned DCADDR_LOW_BIT_W = 8,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [ADDR_W_IN_BITS-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_W_IN_BYTES*8-1:0]  s_axi_wdata,
  input  logic [DATA_W_IN_BYTES-1:0]    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [ADDR_W_IN_BITS-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_W_IN_BYTES*8-1:0]  s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          reg_bank_wr_start,
  input  logic                          reg_bank_wr_done,
  output logic [DCADDR_LOW_BIT_W-1:0]   reg_bank_wr_addr,
  output logic [DATA_W_IN_BYTES*8-1:0]  reg_bank_wr_data,
  output logic                          reg_bank_rd_start,
  input  logic                          reg_bank_rd_done,
  output logic [DCADDR_LOW_BIT_W-1:0]   reg_bank_rd_addr,
  input  logic [DATA_W_IN_BYTES*8-1:0]  reg_bank_rd_data,
  output logic [2:0]                    o_dbg_state
);

  localparam int unsigned DW = DATA_W_IN_BYTES * 8;
  localparam int unsigned AL = DCADDR_LOW_BIT_W;

  // Handshakes: a transfer happens on a rising ACLK where VALID and READY are both high.
  // VALID never waits on READY; READY may depend on VALID-independent state only.

  bridge_state_t r_state, w_state_nxt;

  logic            r_rdy_en;
  logic            r_aw_held, r_w_held, r_ar_held;
  logic [AL-1:0]   r_awaddr, r_araddr;
  logic [DW-1:0]   r_wdata;
  logic [DATA_W_IN_BYTES-1:0] r_wstrb;
  logic            r_wr_prio;
  logic            r_wr_start, r_rd_start;
  logic [AL-1:0]   r_wr_addr, r_rd_addr;
  logic [DW-1:0]   r_wr_data, r_rdata;
  logic [1:0]      r_bresp, r_rresp;

  logic            w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic            w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd;
  logic [AL-1:0]   w_awaddr, w_araddr;
  logic [DW-1:0]   w_wdata;
  logic [DATA_W_IN_BYTES-1:0] w_wstrb;
  logic            w_strb_full;
  logic            w_expired;
  logic            w_unused;

  assign s_axi_awready = r_rdy_en && !r_aw_held;
  assign s_axi_wready  = r_rdy_en && !r_w_held;
  assign s_axi_arready = r_rdy_en && !r_ar_held;

  assign w_aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
  assign w_ar_hs = s_axi_arvalid && s_axi_arready;
  assign w_b_hs  = (r_state == ST_WR_RESP) && s_axi_bready;
  assign w_r_hs  = (r_state == ST_RD_RESP) && s_axi_rready;

  // A request arriving this cycle is eligible immediately so the grant lands on the handshake edge.
  assign w_awaddr = r_aw_held ? r_awaddr : s_axi_awaddr[AL-1:0];
  assign w_araddr = r_ar_held ? r_araddr : s_axi_araddr[AL-1:0];
  assign w_wdata  = r_w_held  ? r_wdata  : s_axi_wdata;
  assign w_wstrb  = r_w_held  ? r_wstrb  : s_axi_wstrb;
  assign w_strb_full = &w_wstrb;

  assign w_wr_elig  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_rd_elig  = r_ar_held || w_ar_hs;
  assign w_grant_wr = (r_state == ST_IDLE) && w_wr_elig && (!w_rd_elig || r_wr_prio);
  assign w_grant_rd = (r_state == ST_IDLE) && w_rd_elig && (!w_wr_elig || !r_wr_prio);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_wr) begin
          w_state_nxt = w_strb_full ? ST_WR_WAIT : ST_WR_RESP;
        end else if (w_grant_rd) begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: if (reg_bank_wr_done || w_expired) w_state_nxt = ST_WR_RESP;
      ST_RD_WAIT: if (reg_bank_rd_done || w_expired) w_state_nxt = ST_RD_RESP;
      ST_WR_RESP: if (s_axi_bready) w_state_nxt = ST_IDLE;
      ST_RD_RESP: if (s_axi_rready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdy_en   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_ar_held  <= 1'b0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_prio  <= 1'b1;
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_wr_data  <= '0;
      r_rdata    <= '0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axi_awaddr[AL-1:0];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end
      if (w_ar_hs) begin
        r_ar_held <= 1'b1;
        r_araddr  <= s_axi_araddr[AL-1:0];
      end
      if (w_b_hs) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (w_r_hs) begin
        r_ar_held <= 1'b0;
      end
      // Priority flips only when both directions compete, so the loser wins the next collision.
      if ((r_state == ST_IDLE) && w_wr_elig && w_rd_elig) begin
        r_wr_prio <= !r_wr_prio;
      end
      r_wr_start <= w_grant_wr && w_strb_full;
      r_rd_start <= w_grant_rd;
      if (w_grant_wr && w_strb_full) begin
        r_wr_addr <= w_awaddr;
        r_wr_data <= w_wdata;
      end
      if (w_grant_wr && !w_strb_full) begin
        r_bresp <= RESP_SLVERR;
      end
      if (w_grant_rd) begin
        r_rd_addr <= w_araddr;
      end
      if (r_state == ST_WR_WAIT) begin
        if (reg_bank_wr_done) begin
          r_bresp <= RESP_OKAY;
        end else if (w_expired) begin
          r_bresp <= RESP_SLVERR;
        end
      end
      if (r_state == ST_RD_WAIT) begin
        if (reg_bank_rd_done) begin
          r_rdata <= reg_bank_rd_data;
          r_rresp <= RESP_OKAY;
        end else if (w_expired) begin
          r_rdata <= '0;
          r_rresp <= RESP_SLVERR;
        end
      end
    end
  end

`ifdef PC_CTRL_BRIDGE_TIMEOUT_EN
  pc_ctrl_bridge_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_clear    (w_grant_wr || w_grant_rd),
    .i_count_en ((r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT)),
    .o_expired  (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Upper AXI address bits are deliberately dropped by the bank decode.
  assign w_unused = &{1'b0, s_axi_awaddr[ADDR_W_IN_BITS-1:AL], s_axi_araddr[ADDR_W_IN_BITS-1:AL],
                      (TIMEOUT_CYCLES != 0)};

  assign s_axi_bvalid      = (r_state == ST_WR_RESP);
  assign s_axi_bresp       = r_bresp;
  assign s_axi_rvalid      = (r_state == ST_RD_RESP);
  assign s_axi_rresp       = r_rresp;
  assign s_axi_rdata       = r_rdata;
  assign reg_bank_wr_start = r_wr_start;
  assign reg_bank_wr_addr  = r_wr_addr;
  assign reg_bank_wr_data  = r_wr_data;
  assign reg_bank_rd_start = r_rd_start;
  assign reg_bank_rd_addr  = r_rd_addr;
  assign o_dbg_state       = r_state;

endmodule
